// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: shared widths, opcode/funct constants, FSM states and decode record
package alu_issue_ctrl_pkg;
    localparam int DATA_W = 32;
    localparam int OPRN_W = 6;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {IS_IDLE, IS_DECODE, IS_EXEC, IS_WB} state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_MULI  = 6'h1d;

    localparam logic [5:0] FN_SLL = 6'h01;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2a;
    localparam logic [5:0] FN_MUL = 6'h2c;

    typedef struct packed {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [OPRN_W-1:0] oprn;
        logic [REG_AW-1:0] dst;
        logic              ill;
    } dec_t;
endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// reg_file_2r1w: 2**REG_AW x DATA_W register file, two operand reads, debug read, one sync write, R0 reads 0
module reg_file_2r1w
    import alu_issue_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);
    logic [DATA_W-1:0] regs [2**REG_AW];

    // Clear on reset; writes to R0 are discarded so it stays zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data  = (ra_addr  == '0) ? '0 : regs[ra_addr];
    assign rb_data  = (rb_addr  == '0) ? '0 : regs[rb_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: four-cycle issue stage that decodes one instruction, drives the ALU and writes back
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [OPRN_W-1:0] alu_oprn,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              zero_flag,
    output logic              illegal,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    state_t            state, state_n;
    logic              rdy_en;
    logic [31:0]       instr_q;
    logic [REG_AW-1:0] dst_q;
    logic [DATA_W-1:0] res_q;
    logic              zero_q;
    logic [DATA_W-1:0] rs_data, rt_data;
    dec_t              dec;
    logic              accept;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;

    assign opcode = instr_q[31:26];
    assign rs     = instr_q[25:21];
    assign rt     = instr_q[20:16];
    assign rd     = instr_q[15:11];
    assign shamt  = instr_q[10:6];
    assign funct  = instr_q[5:0];
    assign imm    = instr_q[15:0];

    assign instr_ready = rdy_en && state == IS_IDLE;
    assign accept      = instr_valid && instr_ready;

    reg_file_2r1w u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (rs),
        .ra_data  (rs_data),
        .rb_addr  (rt),
        .rb_data  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (state == IS_WB),
        .waddr    (dst_q),
        .wdata    (res_q)
    );

    // Decode the latched instruction into ALU operands, operation and destination
    always_comb begin
        dec = '{op1: rs_data, op2: rt_data, oprn: funct, dst: rd, ill: 1'b0};
        case (opcode)
            OP_RTYPE: begin
                if (funct == FN_SLL || funct == FN_SRL) dec.op2 = {{(DATA_W-5){1'b0}}, shamt};
                else dec.ill = !(funct inside {FN_ADD, FN_SUB, FN_MUL, FN_AND, FN_OR, FN_NOR, FN_SLT});
            end
            OP_ADDI: begin dec.op2 = {{(DATA_W-16){imm[15]}}, imm}; dec.oprn = FN_ADD; dec.dst = rt; end
            OP_MULI: begin dec.op2 = {{(DATA_W-16){imm[15]}}, imm}; dec.oprn = FN_MUL; dec.dst = rt; end
            OP_SLTI: begin dec.op2 = {{(DATA_W-16){imm[15]}}, imm}; dec.oprn = FN_SLT; dec.dst = rt; end
            OP_ANDI: begin dec.op2 = {{(DATA_W-16){1'b0}}, imm}; dec.oprn = FN_AND; dec.dst = rt; end
            OP_ORI:  begin dec.op2 = {{(DATA_W-16){1'b0}}, imm}; dec.oprn = FN_OR;  dec.dst = rt; end
            OP_LUI:  begin dec.op1 = {{(DATA_W-16){1'b0}}, imm}; dec.op2 = DATA_W'(16); dec.oprn = FN_SLL; dec.dst = rt; end
            default: dec.ill = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IS_IDLE;
        else state <= state_n;
    end

    // Next state: one pass through decode/exec/writeback, illegal instructions drop back to idle
    always_comb begin
        state_n = state;
        case (state)
            IS_IDLE:   state_n = accept ? IS_DECODE : IS_IDLE;
            IS_DECODE: state_n = dec.ill ? IS_IDLE : IS_EXEC;
            IS_EXEC:   state_n = IS_WB;
            default:   state_n = IS_IDLE;
        endcase
    end

    // Datapath: latch instruction, load ALU inputs, capture result, publish writeback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en    <= 1'b0;
            instr_q   <= '0;
            alu_op1   <= '0;
            alu_op2   <= '0;
            alu_oprn  <= '0;
            dst_q     <= '0;
            res_q     <= '0;
            zero_q    <= 1'b0;
            wb_valid  <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            zero_flag <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            rdy_en   <= 1'b1;
            wb_valid <= 1'b0;
            illegal  <= 1'b0;
            if (accept) instr_q <= instr;
            if (state == IS_DECODE) begin
                if (dec.ill) begin
                    illegal <= 1'b1;
                end else begin
                    alu_op1  <= dec.op1;
                    alu_op2  <= dec.op2;
                    alu_oprn <= dec.oprn;
                    dst_q    <= dec.dst;
                end
            end
            if (state == IS_EXEC) begin
                res_q  <= alu_out;
                zero_q <= alu_zero;
            end
            if (state == IS_WB) begin
                wb_valid  <= 1'b1;
                wb_addr   <= dst_q;
                wb_data   <= res_q;
                zero_flag <= zero_q;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed vector bench with a behavioural ALU and a register-file scoreboard
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [31:0] alu_op1, alu_op2, alu_out;
    logic [5:0]  alu_oprn;
    logic        alu_zero;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        zero_flag, illegal;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_regs [32];

    typedef struct {
        logic [31:0] instr;
        logic        ill;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        zero;
        logic [5:0]  oprn;
    } vec_t;

    vec_t vecs [19];

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_oprn    (alu_oprn),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .zero_flag   (zero_flag),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Behavioural ALU driven by the DUT's registered operands
    always_comb begin
        alu_out = '0;
        case (alu_oprn)
            6'h20:   alu_out = alu_op1 + alu_op2;
            6'h22:   alu_out = alu_op1 - alu_op2;
            6'h2c:   alu_out = alu_op1 * alu_op2;
            6'h24:   alu_out = alu_op1 & alu_op2;
            6'h25:   alu_out = alu_op1 | alu_op2;
            6'h27:   alu_out = ~(alu_op1 | alu_op2);
            6'h2a:   alu_out = {31'b0, $signed(alu_op1) < $signed(alu_op2)};
            6'h01:   alu_out = alu_op1 << alu_op2;
            6'h02:   alu_out = alu_op1 >> alu_op2;
            default: alu_out = '0;
        endcase
    end
    assign alu_zero = alu_out == '0;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!instr_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", {31'b0, instr_ready}, 32'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int wb_at = -1;
        int ill_at = -1;
        int wb_cnt = 0;
        logic [4:0]  got_addr = '0;
        logic [31:0] got_data = '0;
        logic        got_zero = 1'b0;
        wait_ready();
        instr = v.instr;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (wb_valid) begin
                wb_cnt++;
                if (wb_at < 0) begin
                    wb_at = n;
                    got_addr = wb_addr;
                    got_data = wb_data;
                    got_zero = zero_flag;
                end
            end
            if (illegal && ill_at < 0) ill_at = n;
        end
        chk($sformatf("v%0d_oprn", idx), {26'b0, alu_oprn}, {26'b0, v.oprn});
        if (v.ill) begin
            chk($sformatf("v%0d_illegal_at", idx), ill_at, 32'd1);
            chk($sformatf("v%0d_no_wb", idx), wb_cnt, 32'd0);
            dbg_addr = v.addr;
            #1 chk($sformatf("v%0d_reg_kept", idx), dbg_data, exp_regs[v.addr]);
        end else begin
            chk($sformatf("v%0d_wb_latency", idx), wb_at, 32'd3);
            chk($sformatf("v%0d_wb_pulses", idx), wb_cnt, 32'd1);
            chk($sformatf("v%0d_no_illegal", idx), ill_at, 32'hFFFF_FFFF);
            chk($sformatf("v%0d_wb_addr", idx), {27'b0, got_addr}, {27'b0, v.addr});
            chk($sformatf("v%0d_wb_data", idx), got_data, v.data);
            chk($sformatf("v%0d_zero_flag", idx), {31'b0, got_zero}, {31'b0, v.zero});
            if (v.addr != 5'd0) exp_regs[v.addr] = v.data;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int pulses;
        for (int i = 0; i < 32; i++) exp_regs[i] = '0;
        vecs[0]  = '{itype(OP_ADDI, 5'd0, 5'd1, 16'd3),        1'b0, 5'd1,  32'd3,         1'b0, FN_ADD};
        vecs[1]  = '{itype(OP_ADDI, 5'd0, 5'd2, 16'd4),        1'b0, 5'd2,  32'd4,         1'b0, FN_ADD};
        vecs[2]  = '{rtype(5'd1, 5'd2, 5'd3, 5'd0, FN_ADD),    1'b0, 5'd3,  32'd7,         1'b0, FN_ADD};
        vecs[3]  = '{rtype(5'd3, 5'd1, 5'd4, 5'd0, FN_SUB),    1'b0, 5'd4,  32'd4,         1'b0, FN_SUB};
        vecs[4]  = '{rtype(5'd1, 5'd2, 5'd5, 5'd0, FN_NOR),    1'b0, 5'd5,  32'hFFFF_FFF8, 1'b0, FN_NOR};
        vecs[5]  = '{rtype(5'd1, 5'd2, 5'd6, 5'd0, FN_SLT),    1'b0, 5'd6,  32'd1,         1'b0, FN_SLT};
        vecs[6]  = '{rtype(5'd2, 5'd0, 5'd7, 5'd4, FN_SLL),    1'b0, 5'd7,  32'd64,        1'b0, FN_SLL};
        vecs[7]  = '{rtype(5'd7, 5'd0, 5'd8, 5'd2, FN_SRL),    1'b0, 5'd8,  32'd16,        1'b0, FN_SRL};
        vecs[8]  = '{itype(OP_LUI, 5'd0, 5'd9, 16'h1234),      1'b0, 5'd9,  32'h1234_0000, 1'b0, FN_SLL};
        vecs[9]  = '{rtype(5'd2, 5'd2, 5'd10, 5'd0, FN_MUL),   1'b0, 5'd10, 32'd16,        1'b0, FN_MUL};
        vecs[10] = '{itype(6'h3f, 5'd1, 5'd12, 16'h0001),      1'b1, 5'd12, 32'd0,         1'b0, FN_MUL};
        vecs[11] = '{rtype(5'd1, 5'd2, 5'd12, 5'd0, 6'h3e),    1'b1, 5'd12, 32'd0,         1'b0, FN_MUL};
        vecs[12] = '{rtype(5'd1, 5'd2, 5'd0, 5'd0, FN_ADD),    1'b0, 5'd0,  32'd7,         1'b0, FN_ADD};
        vecs[13] = '{rtype(5'd1, 5'd1, 5'd11, 5'd0, FN_SUB),   1'b0, 5'd11, 32'd0,         1'b1, FN_SUB};
        vecs[14] = '{itype(OP_ANDI, 5'd5, 5'd12, 16'hFF0F),    1'b0, 5'd12, 32'h0000_FF08, 1'b0, FN_AND};
        vecs[15] = '{itype(OP_ORI, 5'd1, 5'd13, 16'h8000),     1'b0, 5'd13, 32'h0000_8003, 1'b0, FN_OR};
        vecs[16] = '{itype(OP_SLTI, 5'd5, 5'd14, 16'hFFFF),    1'b0, 5'd14, 32'd1,         1'b0, FN_SLT};
        vecs[17] = '{itype(OP_MULI, 5'd2, 5'd15, 16'hFFFD),    1'b0, 5'd15, 32'hFFFF_FFF4, 1'b0, FN_MUL};
        vecs[18] = '{itype(OP_ADDI, 5'd1, 5'd16, 16'hFFFB),    1'b0, 5'd16, 32'hFFFF_FFFE, 1'b0, FN_ADD};

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, instr_ready}, 32'd0);
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_illegal", {31'b0, illegal}, 32'd0);
        chk("rst_zero_flag", {31'b0, zero_flag}, 32'd0);
        chk("rst_alu_op1", alu_op1, 32'd0);
        chk("rst_alu_oprn", {26'b0, alu_oprn}, 32'd0);
        rst_n = 1'b1;
        #1 chk("release_ready_before_edge", {31'b0, instr_ready}, 32'd0);
        @(posedge clk);
        #1 chk("release_ready_after_edge", {31'b0, instr_ready}, 32'd1);

        instr = itype(OP_ADDI, 5'd0, 5'd1, 16'd3);
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("abort_alu_op2", alu_op2, 32'd0);
        pulses = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (wb_valid) pulses++;
        end
        chk("abort_no_wb", pulses, 32'd0);
        dbg_addr = 5'd1;
        #1 chk("abort_r1_zero", dbg_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_ready_after_release", {31'b0, instr_ready}, 32'd1);

        for (int i = 0; i < 19; i++) run_vec(i, vecs[i]);

        dbg_addr = 5'd0;
        #1 chk("r0_reads_zero", dbg_data, 32'd0);

        wait_ready();
        instr = itype(OP_ADDI, 5'd0, 5'd17, 16'd5);
        instr_valid = 1'b1;
        acc = 0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (instr_ready) acc++;
            @(negedge clk);
            if (wb_valid) pulses++;
        end
        instr_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wb_valid) pulses++;
        end
        chk("held_valid_accepts", acc, 32'd3);
        chk("held_valid_wb_pulses", pulses, 32'd3);
        exp_regs[17] = 32'd5;

        for (int a = 0; a < 18; a++) begin
            dbg_addr = 5'(a);
            #1 chk($sformatf("final_r%0d", a), dbg_data, exp_regs[a]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
